// File: rtl/matrix_block_ram.sv
// Single-port 16x8 block RAM with registered read-first output, preloaded with
// one 3x3 operand image (A or B) for the matrix inner-product engine.
module matrix_block_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int INIT_SEL = 0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);
  localparam int DEPTH = 2**ADDR_W;

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Row-major image, address = 1 + 3*row + col; everything else is zero.
  function automatic mem_t init_image();
    mem_t img;
    img = '0;
    if (INIT_SEL == 0) begin
      img[1] = DATA_W'(1);
      img[5] = DATA_W'(2);
      img[9] = DATA_W'(3);
    end else begin
      img[2] = DATA_W'(4);
      img[4] = DATA_W'(5);
      img[9] = DATA_W'(6);
    end
    return img;
  endfunction

  // Power-up contents only; reset deliberately leaves the array alone.
  mem_t mem_q = init_image();

  logic              wr_en;
  logic [DATA_W-1:0] dout_d, dout_q;

  assign wr_en = ena & wea & ~rsta;

  always_ff @(posedge clka) begin
    if (wr_en) mem_q[addra] <= dina;
  end

  // Read-first: the register samples the array before this edge's write lands.
  always_comb begin
    dout_d = dout_q;
    if (ena) dout_d = mem_q[addra];
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) dout_q <= '0;
    else      dout_q <= dout_d;
  end

  assign douta = dout_q;
endmodule

// File: tb/tb_matrix_block_ram.sv
// Directed bench for matrix_block_ram: an A-image and a B-image instance, with
// expected read data queued at issue time and checked one edge later.
module tb_matrix_block_ram;
  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena_a = 1'b0, wea_a = 1'b0, ena_b = 1'b0, wea_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0;
  logic [7:0] din_a = '0, din_b = '0;
  logic [7:0] dout_a, dout_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] am[9];
  logic [7:0] bm[9];
  logic [7:0] cm;
  logic [7:0] c_exp[9];

  matrix_block_ram #(.DATA_W(8), .ADDR_W(4), .INIT_SEL(0)) u_a (
    .clka(clk), .rsta(rst), .ena(ena_a), .wea(wea_a),
    .addra(addr_a), .dina(din_a), .douta(dout_a)
  );

  matrix_block_ram #(.DATA_W(8), .ADDR_W(4), .INIT_SEL(1)) u_b (
    .clka(clk), .rsta(rst), .ena(ena_b), .wea(wea_b),
    .addra(addr_b), .dina(din_b), .douta(dout_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    assert (act === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drv_a(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    ena_a = en; wea_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic drv_b(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    ena_b = en; wea_b = we; addr_b = ad; din_b = d;
  endtask

  task automatic push_a(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.exp = e;
    qa.push_back(x);
  endtask

  task automatic push_b(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.exp = e;
    qb.push_back(x);
  endtask

  // One active edge, then compare whatever was issued for it.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      chk(x.tag, dout_a, x.exp);
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      chk(x.tag, dout_b, x.exp);
    end
  endtask

  initial begin
    logic [7:0] b_stream[10];
    b_stream = '{8'd0, 8'd0, 8'd4, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6};
    c_exp    = '{8'd0, 8'd4, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd18};

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    #2;
    chk("rst_noclk_a", dout_a, 8'h00);
    chk("rst_noclk_b", dout_b, 8'h00);

    // Reset holds output across edges even with reads enabled.
    drv_a(1'b1, 1'b0, 4'd5, 8'h00);
    drv_b(1'b1, 1'b0, 4'd4, 8'h00);
    tick();
    chk("rst_hold_a", dout_a, 8'h00);
    chk("rst_hold_b", dout_b, 8'h00);

    // First edge after release reads addr 5.
    rst = 1'b0;
    push_a("first_read_a5", 8'd2);
    push_b("first_read_b4", 8'd5);
    tick();

    // Back-to-back stream of B, addresses 0..9.
    drv_a(1'b0, 1'b0, 4'd0, 8'h00);
    push_a("stream_idle_a", 8'd2);
    for (int i = 0; i < 10; i++) begin
      drv_b(1'b1, 1'b0, 4'(i), 8'h00);
      push_b($sformatf("stream_b%0d", i), b_stream[i]);
      tick();
    end

    // Both operands streamed in parallel and multiplied.
    for (int i = 0; i < 9; i++) begin
      drv_a(1'b1, 1'b0, 4'(i + 1), 8'h00);
      drv_b(1'b1, 1'b0, 4'(i + 1), 8'h00);
      tick();
      am[i] = dout_a;
      bm[i] = dout_b;
    end
    drv_b(1'b0, 1'b0, 4'd0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cm = 8'd0;
        for (int k = 0; k < 3; k++) cm = cm + am[3*r+k] * bm[3*k+c];
        chk($sformatf("sys_c%0d%0d", r, c), cm, c_exp[3*r+c]);
      end
    end

    // Read-first write, then read-back on the next edge.
    drv_a(1'b1, 1'b1, 4'd2, 8'h7F);
    push_a("wr_oldval_a2", 8'd0);
    tick();
    drv_a(1'b1, 1'b0, 4'd2, 8'h00);
    push_a("wr_readback_a2", 8'h7F);
    tick();

    // Address 15 then wrap to 0.
    drv_a(1'b1, 1'b1, 4'd15, 8'hF5);
    push_a("wr_oldval_a15", 8'd0);
    tick();
    drv_a(1'b1, 1'b0, 4'd15, 8'h00);
    push_a("read_a15", 8'hF5);
    tick();
    drv_a(1'b1, 1'b0, 4'd0, 8'h00);
    push_a("wrap_a0", 8'd0);
    tick();

    // Enable low blocks both read and write.
    drv_a(1'b1, 1'b0, 4'd9, 8'h00);
    push_a("read_a9", 8'd3);
    tick();
    drv_a(1'b0, 1'b1, 4'd9, 8'hAA);
    push_a("ena0_hold", 8'd3);
    tick();
    drv_a(1'b0, 1'b0, 4'd5, 8'h00);
    push_a("ena0_addr_change", 8'd3);
    tick();
    drv_a(1'b1, 1'b0, 4'd9, 8'h00);
    push_a("reread_a9", 8'd3);
    tick();

    // Mid-stream asynchronous reset; writes during reset are dropped.
    drv_a(1'b1, 1'b0, 4'd5, 8'h00);
    push_a("pre_rst_a5", 8'd2);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_async", dout_a, 8'h00);
    drv_a(1'b1, 1'b1, 4'd2, 8'h55);
    tick();
    chk("midrst_hold", dout_a, 8'h00);
    rst = 1'b0;
    drv_a(1'b1, 1'b0, 4'd2, 8'h00);
    push_a("post_rst_a2", 8'h7F);
    tick();
    drv_a(1'b1, 1'b0, 4'd1, 8'h00);
    push_a("post_rst_a1", 8'd1);
    tick();
    drv_a(1'b0, 1'b0, 4'd0, 8'h00);

    chk("sb_empty_a", 8'(qa.size()), 8'd0);
    chk("sb_empty_b", 8'(qb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
